// File: rtl/board_io_cond_pkg.sv
// Shared constants and helpers for the board-edge conditioner: reset FSM
// encodings and a width helper that never returns less than one bit.
package board_io_cond_pkg;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_STRETCH = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  // Bits needed to hold 0..value-1; a value of 1 still yields a 1-bit field.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/board_io_cond_btn_debounce.sv
// One button channel: polarity normalisation, 2-FF synchroniser, stability
// counter, debounced level and a single-cycle press pulse.
module board_io_cond_btn_debounce
  import board_io_cond_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // Any cycle where the synchronised input agrees with the level restarts the
  // stability window, so chatter shorter than the window never gets through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_1 <= raw ^ ACTIVE_LOW;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_2;
        press <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_io_cond.sv
// Board-edge conditioner: debounced buttons, lock-gated stretched system reset
// and a paged view of a wide status bus on a narrow LED bank.
module board_io_cond
  import board_io_cond_pkg::*;
#(
  parameter int                 NUM_BTN          = 2,
  parameter logic [NUM_BTN-1:0] BTN_ACTIVE_LOW   = {NUM_BTN{1'b1}},
  parameter bit                 PAGE_ACTIVE_LOW  = 1'b1,
  parameter int                 DEBOUNCE_CYCLES  = 1000000,
  parameter int                 LOCK_STRETCH     = 16,
  parameter int                 LED_IN_W         = 8,
  parameter int                 LED_OUT_W        = 4,
  parameter int                 AUTO_PAGE_CYCLES = 0
) (
  input  logic                                           CLK,
  input  logic                                           nRESET,
  input  logic                                           DCM_LOCKED,
  input  logic [NUM_BTN-1:0]                             BTN_RAW,
  input  logic                                           PAGE_RAW,
  input  logic [LED_IN_W-1:0]                            LED_IN,
  output logic                                           SYS_RESET,
  output logic [NUM_BTN-1:0]                             BTN_LEVEL,
  output logic [NUM_BTN-1:0]                             BTN_PRESS,
  output logic [clog2_min1(LED_IN_W / LED_OUT_W)-1:0]    PAGE,
  output logic [LED_OUT_W-1:0]                           LED_OUT
);

  localparam int NCH    = NUM_BTN + 1;
  localparam int NPAGES = LED_IN_W / LED_OUT_W;
  localparam int PAGE_W = clog2_min1(NPAGES);
  localparam int SW     = clog2_min1(LOCK_STRETCH);
  localparam logic [PAGE_W-1:0] PAGE_LAST    = PAGE_W'(NPAGES - 1);
  localparam logic [SW-1:0]     STRETCH_LAST = SW'(LOCK_STRETCH - 1);
  localparam logic [NCH-1:0]    CH_ACTIVE_LOW = {PAGE_ACTIVE_LOW, BTN_ACTIVE_LOW};

  if (LED_IN_W % LED_OUT_W != 0) begin : g_bad_led_w
    $error("LED_IN_W must be a multiple of LED_OUT_W");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LOCK_STRETCH < 1) begin : g_bad_stretch
    $error("LOCK_STRETCH must be at least 1");
  end

  logic [NCH-1:0] ch_raw;
  logic [NCH-1:0] ch_level;
  logic [NCH-1:0] ch_press;
  logic           page_press;
  logic           page_level_unused;

  assign ch_raw = {PAGE_RAW, BTN_RAW};

  for (genvar i = 0; i < NCH; i++) begin : g_deb
    board_io_cond_btn_debounce #(
      .ACTIVE_LOW     (CH_ACTIVE_LOW[i]),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (CLK),
      .rst_n(nRESET),
      .raw  (ch_raw[i]),
      .level(ch_level[i]),
      .press(ch_press[i])
    );
  end

  assign BTN_LEVEL         = ch_level[NUM_BTN-1:0];
  assign BTN_PRESS         = ch_press[NUM_BTN-1:0];
  assign page_press        = ch_press[NUM_BTN];
  assign page_level_unused = ch_level[NUM_BTN];

  logic          lock_meta;
  logic          lock_sync;
  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [SW-1:0] stretch_cnt;

  always_comb begin
    state_next = state;
    case (state)
      ST_HOLD:    if (lock_sync) state_next = ST_STRETCH;
      ST_STRETCH: begin
        if (!lock_sync)                       state_next = ST_HOLD;
        else if (stretch_cnt == STRETCH_LAST) state_next = ST_RUN;
      end
      ST_RUN:     if (!lock_sync) state_next = ST_HOLD;
      default:    state_next = ST_HOLD;
    endcase
  end

  // SYS_RESET is decoded from the next state so it changes on the same edge
  // as the FSM; the stretch count restarts whenever STRETCH is (re)entered.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      lock_meta   <= 1'b0;
      lock_sync   <= 1'b0;
      state       <= ST_HOLD;
      stretch_cnt <= '0;
      SYS_RESET   <= 1'b1;
    end else begin
      lock_meta   <= DCM_LOCKED;
      lock_sync   <= lock_meta;
      state       <= state_next;
      stretch_cnt <= (state == ST_STRETCH && state_next == ST_STRETCH) ?
                     stretch_cnt + 1'b1 : '0;
      SYS_RESET   <= (state_next != ST_RUN);
    end
  end

  logic auto_tick;

  if (AUTO_PAGE_CYCLES > 0) begin : g_auto
    localparam int AW = clog2_min1(AUTO_PAGE_CYCLES);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PAGE_CYCLES - 1);
    logic [AW-1:0] auto_cnt;

    always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET)                             auto_cnt <= '0;
      else if (page_press || auto_cnt == AUTO_LAST) auto_cnt <= '0;
      else                                     auto_cnt <= auto_cnt + 1'b1;
    end

    assign auto_tick = (auto_cnt == AUTO_LAST);
  end else begin : g_manual
    assign auto_tick = 1'b0;
  end

  logic [LED_OUT_W-1:0] led_pages [NPAGES];

  for (genvar p = 0; p < NPAGES; p++) begin : g_pages
    assign led_pages[p] = LED_IN[p*LED_OUT_W +: LED_OUT_W];
  end

  // A manual press landing on an auto tick still advances only one page.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      PAGE    <= '0;
      LED_OUT <= '0;
    end else begin
      if (page_press || auto_tick) PAGE <= (PAGE == PAGE_LAST) ? '0 : PAGE + 1'b1;
      LED_OUT <= led_pages[PAGE];
    end
  end

endmodule

// File: tb/tb_board_io_cond.sv
// Directed bench for board_io_cond: debounce latency and chatter rejection,
// lock-gated reset stretching, manual/auto paging and asynchronous reset.
module tb_board_io_cond;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       dcm_locked;
  logic [1:0] btn_raw;
  logic       page_raw;
  logic       page_raw_auto;
  logic [7:0] led_in;

  logic       sys_reset,   sys_reset_a;
  logic [1:0] btn_level,   btn_level_a;
  logic [1:0] btn_press,   btn_press_a;
  logic       page,        page_a;
  logic [3:0] led_out,     led_out_a;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  board_io_cond #(
    .NUM_BTN(2), .BTN_ACTIVE_LOW(2'b01), .PAGE_ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(4), .LOCK_STRETCH(3), .LED_IN_W(8), .LED_OUT_W(4),
    .AUTO_PAGE_CYCLES(0)
  ) dut (
    .CLK(clk), .nRESET(n_reset), .DCM_LOCKED(dcm_locked), .BTN_RAW(btn_raw),
    .PAGE_RAW(page_raw), .LED_IN(led_in), .SYS_RESET(sys_reset),
    .BTN_LEVEL(btn_level), .BTN_PRESS(btn_press), .PAGE(page), .LED_OUT(led_out)
  );

  board_io_cond #(
    .NUM_BTN(2), .BTN_ACTIVE_LOW(2'b01), .PAGE_ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(4), .LOCK_STRETCH(3), .LED_IN_W(8), .LED_OUT_W(4),
    .AUTO_PAGE_CYCLES(8)
  ) dut_auto (
    .CLK(clk), .nRESET(n_reset), .DCM_LOCKED(dcm_locked), .BTN_RAW(btn_raw),
    .PAGE_RAW(page_raw_auto), .LED_IN(led_in), .SYS_RESET(sys_reset_a),
    .BTN_LEVEL(btn_level_a), .BTN_PRESS(btn_press_a), .PAGE(page_a), .LED_OUT(led_out_a)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one button edge and check level/press over the following 8 cycles.
  task automatic applyStimulus(input int idx, input logic raw_val, input logic final_level);
    btn_raw[idx] = raw_val;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("btn%0d_level_c%0d", idx, i), 32'(btn_level[idx]),
                  32'((i >= 6) ? final_level : !final_level));
      checkOutput($sformatf("btn%0d_press_c%0d", idx, i), 32'(btn_press[idx]),
                  32'((i == 6) && final_level));
    end
  endtask

  function automatic logic exp_auto_page(input int e);
    if (e < 8)       return 1'b0;
    else if (e < 16) return 1'b1;
    else if (e < 24) return 1'b0;
    else if (e < 32) return 1'b1;
    else if (e < 34) return 1'b0;
    else if (e < 42) return 1'b1;
    else             return 1'b0;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_reset       = 1'b0;
    dcm_locked    = 1'b0;
    btn_raw       = 2'b01;
    page_raw      = 1'b1;
    page_raw_auto = 1'b1;
    led_in        = 8'hA5;

    repeat (2) @(negedge clk);
    checkOutput("rst_sys_reset", 32'(sys_reset), 32'd1);
    checkOutput("rst_btn_level", 32'(btn_level), 32'd0);
    checkOutput("rst_btn_press", 32'(btn_press), 32'd0);
    checkOutput("rst_page",      32'(page),      32'd0);
    checkOutput("rst_led_out",   32'(led_out),   32'd0);
    checkOutput("rst_page_a",    32'(page_a),    32'd0);
    checkOutput("rst_sys_reset_a", 32'(sys_reset_a), 32'd1);
    checkOutput("rst_led_out_a", 32'(led_out_a), 32'd0);
    checkOutput("rst_btn_a",     32'({btn_level_a, btn_press_a}), 32'd0);

    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("led_page0", 32'(led_out), 32'h5);
    checkOutput("sys_reset_unlocked", 32'(sys_reset), 32'd1);

    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(1, 1'b1, 1'b1);
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);

    // Two-cycle chatter never survives a four-cycle window.
    for (int i = 0; i < 20; i++) begin
      btn_raw[0] = (i % 4 < 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      checkOutput("chatter_level", 32'(btn_level[0]), 32'd0);
      checkOutput("chatter_press", 32'(btn_press[0]), 32'd0);
    end
    repeat (6) @(negedge clk);
    checkOutput("chatter_settled", 32'(btn_level[0]), 32'd0);

    dcm_locked = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("lock_release_c%0d", i), 32'(sys_reset), 32'(i < 6));
    end
    dcm_locked = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("lock_drop_c%0d", i), 32'(sys_reset), 32'(i >= 3));
    end

    // Lock lost while the stretch count is 1; the relock must start over.
    dcm_locked = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("short_lock", 32'(sys_reset), 32'd1);
    end
    dcm_locked = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("short_lock_hold", 32'(sys_reset), 32'd1);
    end
    dcm_locked = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("relock_c%0d", i), 32'(sys_reset), 32'(i < 6));
    end

    page_raw = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checkOutput($sformatf("page_up_c%0d", i), 32'(page), 32'(i >= 7));
      checkOutput($sformatf("led_up_c%0d", i), 32'(led_out), (i >= 8) ? 32'hA : 32'h5);
    end
    page_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checkOutput("page_release", 32'(page), 32'd1);
    end
    page_raw = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checkOutput($sformatf("page_wrap_c%0d", i), 32'(page), 32'(i < 7));
      checkOutput($sformatf("led_wrap_c%0d", i), 32'(led_out), (i >= 8) ? 32'h5 : 32'hA);
    end
    page_raw = 1'b1;
    repeat (8) @(negedge clk);
    led_in = 8'h3C;
    checkOutput("led_latency_before", 32'(led_out), 32'h5);
    @(negedge clk);
    checkOutput("led_latency_after", 32'(led_out), 32'hC);

    btn_raw = 2'b00;
    repeat (8) @(negedge clk);
    checkOutput("pre_reset_level", 32'(btn_level), 32'd1);
    dcm_locked = 1'b0;
    repeat (4) @(negedge clk);
    dcm_locked = 1'b1;
    btn_raw    = 2'b10;
    repeat (4) @(negedge clk);

    n_reset = 1'b0;
    #1;
    checkOutput("async_sys_reset", 32'(sys_reset), 32'd1);
    checkOutput("async_btn_level", 32'(btn_level), 32'd0);
    checkOutput("async_btn_press", 32'(btn_press), 32'd0);
    checkOutput("async_page",      32'(page),      32'd0);
    checkOutput("async_led_out",   32'(led_out),   32'd0);
    checkOutput("async_page_a",    32'(page_a),    32'd0);
    repeat (2) @(negedge clk);
    checkOutput("async_hold", 32'(sys_reset), 32'd1);

    // Auto paging every 8 cycles; first manual press lands on the tick at 16.
    n_reset = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(negedge clk);
      checkOutput($sformatf("auto_page_e%0d", e), 32'(page_a), 32'(exp_auto_page(e)));
      if (e <= 10) begin
        checkOutput($sformatf("rerun_sys_reset_e%0d", e), 32'(sys_reset), 32'(e < 6));
        checkOutput($sformatf("rerun_level_e%0d", e), 32'(btn_level), (e >= 6) ? 32'd3 : 32'd0);
        checkOutput($sformatf("rerun_press_e%0d", e), 32'(btn_press), (e == 6) ? 32'd3 : 32'd0);
      end
      if (e == 9)  page_raw_auto = 1'b0;
      if (e == 17) page_raw_auto = 1'b1;
      if (e == 27) page_raw_auto = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
